// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for one shared N-bit AND/OR/XOR/NOT unit.
// The result is registered with the winner's ID and held until consumed.
module logic_unit_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic [N-1:0] res_data
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state_q;
    logic [N-1:0] res_data_q;
    logic         res_id_q;
    logic         last_q;

    logic         free;
    logic         gnt_valid;
    logic         gnt_id;
    logic         accept;
    logic [1:0]   mux_op;
    logic [N-1:0] mux_a;
    logic [N-1:0] mux_b;
    logic [N-1:0] lu_d;

    assign free = (state_q == IDLE) | res_ready;

    always_comb begin
        gnt_valid = req0_valid | req1_valid;
        gnt_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_q;
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
    end

    // Readys stay low while reset is asserted even though state reads IDLE.
    assign accept     = free & gnt_valid & ~rst;
    assign req0_ready = accept & ~gnt_id;
    assign req1_ready = accept & gnt_id;

    assign mux_op = gnt_id ? req1_op : req0_op;
    assign mux_a  = gnt_id ? req1_a  : req0_a;
    assign mux_b  = gnt_id ? req1_b  : req0_b;

    always_comb begin
        case (mux_op)
            2'b00:   lu_d = mux_a & mux_b;
            2'b01:   lu_d = mux_a | mux_b;
            2'b10:   lu_d = mux_a ^ mux_b;
            default: lu_d = ~mux_a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= HOLD;
                        res_data_q <= lu_d;
                        res_id_q   <= gnt_id;
                        last_q     <= gnt_id;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        res_data_q <= lu_d;
                        res_id_q   <= gnt_id;
                        last_q     <= gnt_id;
                    end else if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid = (state_q == HOLD);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one N-bit bitwise logic unit (AND/OR/XOR/NOT) between two requesters in the ALU logic section. Each requester presents operands and an opcode under a valid/ready handshake. A round-robin arbiter grants one request per cycle. The result is registered with the winning requester's ID and held under a valid/ready handshake until the consumer takes it.

## Interface
Parameters:
- N, 4, operand/result width in bits (N >= 1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle when high with req0_valid
- req0_op  in  2  requester 0 opcode
- req0_a  in  N  requester 0 operand A
- req0_b  in  N  requester 0 operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- res_valid  out  1  res_data/res_id hold a result
- res_ready  in  1  consumer accepts result when high with res_valid
- res_id  out  1  requester that produced the held result
- res_data  out  N  result

## Operation
- Opcodes: 00 = a & b, 01 = a | b, 10 = a ^ b, 11 = ~a (b ignored).
- All results are exactly N bits. There is no carry and no flags.
- One shared logic unit is used. Its operands and opcode are muxed from the granted requester.
- FSM states:
  - IDLE: no result held. res_valid = 0.
  - HOLD: result held. res_valid = 1.
- free = (state == IDLE) | (state == HOLD & res_ready).
- Grant (combinational):
  - Only req0_valid high -> requester 0.
  - Only req1_valid high -> requester 1.
  - Both high -> the requester not equal to last_grant.
  - Neither high -> no grant.
- reqX_ready = free & grant==X. At most one ready is high per cycle.
- Ready depends combinationally on res_ready and both valids. Requesters must not make valid depend on ready.
- Accept on a clock edge when the granted requester's valid and ready are both high. On accept:
  - res_data <= op(a, b)
  - res_id <= grant
  - last_grant <= grant
  - state -> HOLD
- HOLD with res_ready high and no accept -> IDLE, res_valid falls.
- HOLD with res_ready high and an accept -> stay in HOLD; the new result replaces the old one (back-to-back).
- HOLD with res_ready low: res_data and res_id are frozen, and both readys are low.
- last_grant changes only on accept.

## Timing
- Reset values: state = IDLE, res_valid = 0, res_data = 0, res_id = 0, last_grant = 1 (requester 0 wins the first tie), req0_ready = req1_ready = 0 while rst is high.
- Reset is asynchronous. Asserting it mid-operation immediately discards any held result and clears the outputs to their reset values. First accept is possible at the first rising edge after rst deasserts.
- Latency: accept at edge k -> res_valid = 1 and res_data valid after edge k (1 cycle).
- Throughput: one result per cycle when res_ready is held high.
- With both requesters continuously valid and res_ready high, grants alternate 0,1,0,1… No requester waits more than one grant.
- Simultaneous consume and accept in the same cycle is legal and must not drop or duplicate a result.
- Inputs change only after a clock edge. Operands and opcode are sampled only at the accept edge.

## Test plan
- Reset/tie: rst high then low; both valid with req0 = {op 00, a=0011, b=0101} and req1 = {op 01, a=1000, b=0001}, res_ready=1 -> first result id 0, data 0001; next cycle id 1, data 1001.
- Opcode sweep: req0 only, a=1001, b=1011, ops 00/01/10/11 back-to-back, res_ready=1 -> 1001, 1011, 0010, 0110 on consecutive cycles, id 0.
- Backpressure: res_ready=0 after first accept of AND 1111&1111 -> res_valid held 1, res_data 1111, both readys 0 for 5 cycles; raising res_ready completes the handshake with the same 1111.
- Fairness: both valid for 8 cycles, res_ready=1 -> res_id sequence 0,1,0,1,0,1,0,1 with no duplicated or missing result.
- Single requester: only req1 valid for 4 cycles -> four id-1 results on consecutive cycles. req1_ready high every cycle, req0_ready low.
- Mid-operation reset: result held (res_ready=0), assert rst between edges -> res_valid, res_data, res_id go to 0 without waiting for a clock edge; after release, a tie goes to requester 0.
